// File: rtl/stq_pkg.sv
// Shared types and helpers for the store queue.
// Holds the queue geometry, the per-entry record and the word-address compare.
package stq_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned STQ_BUF_SIZE  = 8;
  localparam int unsigned ROB_TAG_WIDTH = 5;
  localparam int unsigned STQ_IDX_W     = $clog2(STQ_BUF_SIZE);
  localparam int unsigned STQ_PTR_W     = STQ_IDX_W + 1;

  typedef logic [STQ_IDX_W-1:0]     stq_idx_t;
  typedef logic [STQ_PTR_W-1:0]     stq_ptr_t;
  typedef logic [XLEN-1:0]          xlen_t;
  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic     valid;
    xlen_t    addr;
    logic     addr_valid;
    xlen_t    data;
    logic     data_valid;
    logic     committed;
    rob_tag_t rob_tag;
  } stq_entry_t;

  // Full-word stores only: ignore the byte offset when matching.
  function automatic logic word_addr_match(input xlen_t a, input xlen_t b);
    return ((a ^ b) >> 2) == '0;
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Store queue bus bundle: allocation, address/data resolve, commit/flush,
// memory drain port and the combinational load-forwarding query.
// master = LSU/core side driving requests, slave = the store queue.
interface store_queue_if;
  import stq_pkg::*;

  logic     alloc_valid;
  rob_tag_t alloc_rob_tag;
  logic     alloc_ready;
  stq_idx_t alloc_index;

  logic     addr_wr_valid;
  stq_idx_t addr_wr_index;
  xlen_t    addr_wr;
  logic     data_wr_valid;
  stq_idx_t data_wr_index;
  xlen_t    data_wr;

  logic     commit_valid;
  logic     flush;

  logic     mem_wr_valid;
  xlen_t    mem_wr_addr;
  xlen_t    mem_wr_data;
  logic     mem_wr_ready;

  logic [STQ_BUF_SIZE-1:0] valid_mask;

  xlen_t                   fwd_addr;
  logic [STQ_BUF_SIZE-1:0] fwd_store_mask;
  logic                    fwd_hit;
  stq_idx_t                fwd_index;
  xlen_t                   fwd_data;
  logic                    fwd_stall;

  logic full;
  logic empty;

  modport master (
    output alloc_valid, alloc_rob_tag,
    output addr_wr_valid, addr_wr_index, addr_wr,
    output data_wr_valid, data_wr_index, data_wr,
    output commit_valid, flush, mem_wr_ready,
    output fwd_addr, fwd_store_mask,
    input  alloc_ready, alloc_index,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  valid_mask, fwd_hit, fwd_index, fwd_data, fwd_stall,
    input  full, empty
  );

  modport slave (
    input  alloc_valid, alloc_rob_tag,
    input  addr_wr_valid, addr_wr_index, addr_wr,
    input  data_wr_valid, data_wr_index, data_wr,
    input  commit_valid, flush, mem_wr_ready,
    input  fwd_addr, fwd_store_mask,
    output alloc_ready, alloc_index,
    output mem_wr_valid, mem_wr_addr, mem_wr_data,
    output valid_mask, fwd_hit, fwd_index, fwd_data, fwd_stall,
    output full, empty
  );

endinterface

// File: rtl/stq_forward_select.sv
// Age-ordered priority scan for store-to-load forwarding.
// Inputs: head_idx (oldest entry), cand_mask (valid & load dependency),
//         per-entry address-match / address-valid / data-valid vectors.
// Outputs: hit (forward from index), stall (youngest relevant store unresolved).
module stq_forward_select
  import stq_pkg::*;
(
  input  stq_idx_t                head_idx,
  input  logic [STQ_BUF_SIZE-1:0] cand_mask,
  input  logic [STQ_BUF_SIZE-1:0] match_vec,
  input  logic [STQ_BUF_SIZE-1:0] addr_valid_vec,
  input  logic [STQ_BUF_SIZE-1:0] data_valid_vec,
  output logic                    hit,
  output logic                    stall,
  output stq_idx_t                index
);

  // Walk from youngest age (head + N-1) down to head; first decisive candidate wins.
  always_comb begin
    stq_idx_t idx;
    logic     found;
    hit   = 1'b0;
    stall = 1'b0;
    index = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = STQ_BUF_SIZE - 1; k >= 0; k--) begin
      idx = head_idx + stq_idx_t'(k);
      if (!found && cand_mask[idx]) begin
        if (!addr_valid_vec[idx]) begin
          stall = 1'b1;
          found = 1'b1;
        end else if (match_vec[idx]) begin
          found = 1'b1;
          if (data_valid_vec[idx]) begin
            hit   = 1'b1;
            index = idx;
          end else begin
            stall = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Circular LSU store queue: in-order allocate, out-of-order address/data
// resolve, in-order commit and drain to memory, combinational forwarding.
// Ports: clk, reset (sync, active-high), sq (store_queue_if.slave bundle).
module store_queue
  import stq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  store_queue_if.slave sq
);

  stq_entry_t entries_q [STQ_BUF_SIZE];
  stq_entry_t entries_d [STQ_BUF_SIZE];
  stq_ptr_t   head_q, head_d, commit_q, commit_d, tail_q, tail_d;

  stq_ptr_t   count;
  stq_idx_t   head_idx, commit_idx, tail_idx;
  stq_entry_t head_entry;
  logic       full_w, alloc_fire, commit_fire, drain_fire, mem_wr_valid_w;
  logic [STQ_BUF_SIZE-1:0] valid_vec, match_vec, addr_valid_vec, data_valid_vec;
  logic       fwd_hit_w, fwd_stall_w;
  stq_idx_t   fwd_idx_w;
  logic       unused_rob_tag;

  assign head_idx   = stq_idx_t'(head_q);
  assign commit_idx = stq_idx_t'(commit_q);
  assign tail_idx   = stq_idx_t'(tail_q);
  assign count      = tail_q - head_q;
  assign full_w     = (count == stq_ptr_t'(STQ_BUF_SIZE));
  assign head_entry = entries_q[head_idx];

  assign mem_wr_valid_w = head_entry.valid && head_entry.committed &&
                          head_entry.addr_valid && head_entry.data_valid;
  // Fullness comes from registered count, so a same-cycle drain never frees a slot.
  assign alloc_fire  = sq.alloc_valid && !full_w && !sq.flush;
  // Commit with nothing uncommitted is a protocol error and is dropped.
  assign commit_fire = sq.commit_valid && (commit_q != tail_q);
  assign drain_fire  = mem_wr_valid_w && sq.mem_wr_ready;

  // Per-entry status vectors for forwarding and the valid snapshot.
  always_comb begin
    valid_vec      = '0;
    match_vec      = '0;
    addr_valid_vec = '0;
    data_valid_vec = '0;
    unused_rob_tag = 1'b0;
    for (int i = 0; i < STQ_BUF_SIZE; i++) begin
      valid_vec[i]      = entries_q[i].valid;
      match_vec[i]      = word_addr_match(entries_q[i].addr, sq.fwd_addr);
      addr_valid_vec[i] = entries_q[i].addr_valid;
      data_valid_vec[i] = entries_q[i].data_valid;
      unused_rob_tag    = unused_rob_tag ^ (^entries_q[i].rob_tag);
    end
  end

  // Next state; same-edge events resolve as commit, then flush, then drain.
  always_comb begin
    stq_ptr_t flush_len;
    stq_idx_t clr_idx;
    entries_d = entries_q;
    head_d    = head_q;
    commit_d  = commit_q;
    tail_d    = tail_q;
    flush_len = '0;
    clr_idx   = '0;

    if (sq.addr_wr_valid && entries_q[sq.addr_wr_index].valid) begin
      entries_d[sq.addr_wr_index].addr       = sq.addr_wr;
      entries_d[sq.addr_wr_index].addr_valid = 1'b1;
    end
    if (sq.data_wr_valid && entries_q[sq.data_wr_index].valid) begin
      entries_d[sq.data_wr_index].data       = sq.data_wr;
      entries_d[sq.data_wr_index].data_valid = 1'b1;
    end

    if (alloc_fire) begin
      entries_d[tail_idx]         = '0;
      entries_d[tail_idx].valid   = 1'b1;
      entries_d[tail_idx].rob_tag = sq.alloc_rob_tag;
      tail_d                      = tail_q + stq_ptr_t'(1);
    end

    if (commit_fire) begin
      entries_d[commit_idx].committed = 1'b1;
      commit_d                        = commit_q + stq_ptr_t'(1);
    end

    // Flush starts after this cycle's commit so the just-committed entry survives.
    if (sq.flush) begin
      flush_len = tail_q - commit_d;
      for (int k = 0; k < STQ_BUF_SIZE; k++) begin
        if (stq_ptr_t'(k) < flush_len) begin
          clr_idx            = stq_idx_t'(commit_d) + stq_idx_t'(k);
          entries_d[clr_idx] = '0;
        end
      end
      tail_d = commit_d;
    end

    if (drain_fire) begin
      entries_d[head_idx] = '0;
      head_d              = head_q + stq_ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STQ_BUF_SIZE; i++) entries_q[i] <= '0;
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      commit_q  <= commit_d;
      tail_q    <= tail_d;
    end
  end

  stq_forward_select u_fwd_sel (
    .head_idx       (head_idx),
    .cand_mask      (valid_vec & sq.fwd_store_mask),
    .match_vec      (match_vec),
    .addr_valid_vec (addr_valid_vec),
    .data_valid_vec (data_valid_vec),
    .hit            (fwd_hit_w),
    .stall          (fwd_stall_w),
    .index          (fwd_idx_w)
  );

  assign sq.alloc_ready  = !full_w;
  assign sq.alloc_index  = tail_idx;
  assign sq.full         = full_w;
  assign sq.empty        = (count == '0);
  assign sq.valid_mask   = valid_vec;
  assign sq.mem_wr_valid = mem_wr_valid_w;
  assign sq.mem_wr_addr  = mem_wr_valid_w ? head_entry.addr : '0;
  assign sq.mem_wr_data  = mem_wr_valid_w ? head_entry.data : '0;
  assign sq.fwd_hit      = fwd_hit_w;
  assign sq.fwd_stall    = fwd_stall_w;
  assign sq.fwd_index    = fwd_idx_w;
  assign sq.fwd_data     = fwd_hit_w ? entries_q[fwd_idx_w].data : '0;

endmodule
